// File: rtl/param_up_down_counter.sv
// Parametrised single-clock up/down counter with programmable terminal value,
// wrap/saturate boundary behaviour, parallel load, terminal-count pulse and sticky flags.
module param_up_down_counter #(
  parameter int unsigned       WIDTH    = 4,
  parameter logic [WIDTH-1:0]  MAX_VAL  = '1,
  parameter bit                SATURATE = 1'b0,
  parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic at_top, at_bot;
  assign at_top = (count_q == MAX_VAL);
  assign at_bot = (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    // Clear first so a same-edge boundary event below wins for its own flag.
    ovf_d   = ovf_q & ~clr_flags;
    unf_d   = unf_q & ~clr_flags;
    if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (!mode) begin
        if (at_top) begin
          count_d = SATURATE ? MAX_VAL : '0;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_bot) begin
          count_d = SATURATE ? '0 : MAX_VAL;
          tc_d    = 1'b1;
          unf_d   = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RST_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_param_up_down_counter.sv
// Three counter configurations share one stimulus stream and are compared
// against an arithmetic reference model every cycle, plus directed checkpoints.
module tb_param_up_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, mode = 1'b0, load = 1'b0, clr_flags = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] cnt_o [3];
  logic       tc_o  [3];
  logic       ovf_o [3];
  logic       unf_o [3];

  always #5 clk = ~clk;

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(4'd9),  .SATURATE(1'b0), .RST_VAL(4'd0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0]));

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b1), .RST_VAL(4'd0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1]));

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(4'd9),  .SATURATE(1'b0), .RST_VAL(4'd7)) u_rst7 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .count(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]), .unf(unf_o[2]));

  int mx  [3] = '{9, 15, 9};
  int sat [3] = '{0, 1, 0};
  int rv  [3] = '{0, 0, 7};
  int m_c [3];
  int m_tc[3], m_ovf[3], m_unf[3];
  int total = 0, bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_rst();
    for (int i = 0; i < 3; i++) begin
      m_c[i] = rv[i]; m_tc[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end
  endfunction

  // Counting range is the ring 0..mx; modulo arithmetic for wrap, clamping for saturate.
  function automatic void model_step();
    for (int i = 0; i < 3; i++) begin
      int nxt;
      if (clr_flags) begin m_ovf[i] = 0; m_unf[i] = 0; end
      m_tc[i] = 0;
      if (load) begin
        m_c[i] = (int'(load_val) < mx[i]) ? int'(load_val) : mx[i];
      end else if (en) begin
        nxt = mode ? m_c[i] - 1 : m_c[i] + 1;
        if (nxt > mx[i] || nxt < 0) begin
          m_tc[i] = 1;
          if (mode) m_unf[i] = 1; else m_ovf[i] = 1;
        end
        if (sat[i] != 0) m_c[i] = (nxt > mx[i]) ? mx[i] : (nxt < 0 ? 0 : nxt);
        else             m_c[i] = (nxt + mx[i] + 1) % (mx[i] + 1);
      end
    end
  endfunction

  task automatic check_all(input string ph);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_cnt%0d", ph, i), int'(cnt_o[i]), m_c[i]);
      chk($sformatf("%s_tc%0d",  ph, i), int'(tc_o[i]),  m_tc[i]);
      chk($sformatf("%s_ovf%0d", ph, i), int'(ovf_o[i]), m_ovf[i]);
      chk($sformatf("%s_unf%0d", ph, i), int'(unf_o[i]), m_unf[i]);
    end
  endtask

  task automatic cyc(input string ph, input logic e, input logic m, input logic ld,
                     input logic [3:0] lv, input logic c);
    en = e; mode = m; load = ld; load_val = lv; clr_flags = c;
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
  endtask

  // Assert reset between edges, verify outputs before any edge, release after the next edge.
  task automatic async_rst(input string ph);
    #3 rst = 1'b0;
    model_rst();
    #1 check_all({ph, "_async"});
    @(posedge clk);
    #1 rst = 1'b1;
    check_all({ph, "_held"});
  endtask

  initial begin
    int ovf_before;
    model_rst();
    repeat (3) @(posedge clk);
    #1 check_all("reset");
    chk("reset_rst7", int'(cnt_o[2]), 7);
    rst = 1'b1;

    for (int k = 0; k < 10; k++) cyc("upwrap", 1, 0, 0, 0, 0);
    chk("upwrap_cnt", int'(cnt_o[0]), 0);
    chk("upwrap_tc",  int'(tc_o[0]), 1);
    chk("upwrap_ovf", int'(ovf_o[0]), 1);
    chk("upwrap_unf", int'(unf_o[0]), 0);

    for (int k = 0; k < 5; k++) cyc("up5", 1, 0, 0, 0, 0);
    chk("up5_cnt", int'(cnt_o[0]), 5);
    for (int k = 0; k < 6; k++) cyc("down", 1, 1, 0, 0, 0);
    chk("down_cnt", int'(cnt_o[0]), 9);
    chk("down_tc",  int'(tc_o[0]), 1);
    chk("down_unf", int'(unf_o[0]), 1);
    cyc("clr", 0, 1, 0, 0, 1);
    chk("clr_ovf", int'(ovf_o[0]), 0);
    chk("clr_unf", int'(unf_o[0]), 0);
    chk("clr_tc",  int'(tc_o[0]), 0);

    cyc("sat_ld", 0, 0, 1, 4'd14, 0);
    chk("sat_ld_cnt", int'(cnt_o[1]), 14);
    chk("sat_ld_clamp", int'(cnt_o[0]), 9);
    cyc("sat1", 1, 0, 0, 0, 0);
    chk("sat1_cnt", int'(cnt_o[1]), 15);
    chk("sat1_tc",  int'(tc_o[1]), 0);
    cyc("sat2", 1, 0, 0, 0, 0);
    chk("sat2_cnt", int'(cnt_o[1]), 15);
    chk("sat2_tc",  int'(tc_o[1]), 1);
    cyc("sat3", 1, 0, 0, 0, 0);
    chk("sat3_cnt", int'(cnt_o[1]), 15);
    chk("sat3_tc",  int'(tc_o[1]), 1);
    chk("sat3_ovf", int'(ovf_o[1]), 1);
    cyc("sat_ld0", 0, 0, 1, 4'd0, 0);
    cyc("satdn", 1, 1, 0, 0, 0);
    chk("satdn_cnt", int'(cnt_o[1]), 0);
    chk("satdn_unf", int'(unf_o[1]), 1);

    cyc("ld9", 0, 0, 1, 4'd9, 0);
    ovf_before = int'(ovf_o[0]);
    cyc("ldpri", 1, 0, 1, 4'd12, 0);
    chk("ldpri_cnt", int'(cnt_o[0]), 9);
    chk("ldpri_tc",  int'(tc_o[0]), 0);
    chk("ldpri_ovf", int'(ovf_o[0]), ovf_before);
    cyc("ld3", 1, 0, 1, 4'd3, 0);
    chk("ld3_cnt", int'(cnt_o[0]), 3);

    cyc("ld2", 0, 0, 1, 4'd2, 0);
    cyc("en1", 1, 0, 0, 0, 0); chk("en1_cnt", int'(cnt_o[0]), 3);
    cyc("en0", 0, 0, 0, 0, 0); chk("en0_cnt", int'(cnt_o[0]), 3);
    cyc("en0b", 0, 0, 0, 0, 0); chk("en0b_cnt", int'(cnt_o[0]), 3);
    cyc("en1b", 1, 0, 0, 0, 0); chk("en1b_cnt", int'(cnt_o[0]), 4);
    chk("en1b_tc", int'(tc_o[0]), 0);

    cyc("ld4", 0, 0, 1, 4'd4, 0);
    chk("ld4_cnt", int'(cnt_o[2]), 4);
    async_rst("ar");
    chk("ar_cnt", int'(cnt_o[2]), 7);
    cyc("resume", 1, 0, 0, 0, 0);
    chk("resume_cnt", int'(cnt_o[2]), 8);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) async_rst("rnd");
      else cyc("rnd", $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)),
               $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
